sram_fifo_ctrl: RTL and testbench

FIFO controller that sits directly upstream of the single-port synchronous SRAM (`SRAM_S`) and turns it into a first-in/first-out buffer. It accepts a valid/ready write stream, arbitrates one SRAM access per cycle between writes and prefetch reads, and presents a valid/ready read stream from a 2-entry output queue. The controller drives the SRAM's `Dir`, `Dato_e`, `WE` and `En` and consumes its `Dato_s`.

---
 rtl/sram_fifo_pkg.sv | 14 +
 rtl/sram_fifo_oq.sv | 52 +++++
 rtl/sram_fifo_ctrl.sv | 132 +++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared types and default widths for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/sram_fifo_oq.sv
// Two-entry output queue fed by SRAM read returns; entry 0 is always the head.
module sram_fifo_oq
  import sram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        cnt_o
);

  logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        slot;
  logic              pop;

  always_comb begin
    pop   = pop_i && (cnt_q != 2'd0);
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (pop) e0_d = e1_q;
    // incoming word lands in the first free slot left after this cycle's pop
    slot  = cnt_q - {1'b0, pop};
    if (push_i) begin
      if (slot == 2'd0) e0_d = push_dat_i;
      else              e1_d = push_dat_i;
    end
    cnt_d = slot + {1'b0, push_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign vld_o  = (cnt_q != 2'd0);
  assign head_o = e0_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a single-port synchronous SRAM: one write or prefetch read per cycle.
// Optional SRAM_FIFO_STATUS_EN adds registered count / almost_full status ports.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_dir,
  output logic [DATA_W-1:0] mem_dato_e,
  input  logic [DATA_W-1:0] mem_dato_s
`ifdef SRAM_FIFO_STATUS_EN
  ,
  output logic [ADDR_W:0]   count,
  output logic              almost_full
`endif
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              last_wr_q, last_wr_d;
  logic [1:0]        oq_cnt;
  logic              wr_elig, rd_elig, pop_hs;
  gnt_e              gnt;

  // Grants are suppressed while reset is held so no SRAM access leaks out.
  assign wr_elig = rst_n && push_valid && (mem_cnt_q != FULL_CNT);
  assign rd_elig = rst_n && (mem_cnt_q != '0) && ((oq_cnt + {1'b0, rd_pend_q}) < 2'd2);
  assign pop_hs  = pop_valid && pop_ready;

  always_comb begin
    gnt = GNT_NONE;
    if (wr_elig && rd_elig) gnt = last_wr_q ? GNT_RD : GNT_WR;
    else if (wr_elig)       gnt = GNT_WR;
    else if (rd_elig)       gnt = GNT_RD;
  end

  always_comb begin
    push_ready = (gnt == GNT_WR);
    mem_en     = (gnt != GNT_NONE);
    mem_we     = (gnt == GNT_WR);
    mem_dir    = '0;
    mem_dato_e = '0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_cnt_d  = mem_cnt_q;
    rd_pend_d  = (gnt == GNT_RD);
    last_wr_d  = (gnt == GNT_NONE) ? last_wr_q : (gnt == GNT_WR);
    case (gnt)
      GNT_WR: begin
        mem_dir    = wr_ptr_q;
        mem_dato_e = push_data;
        wr_ptr_d   = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        mem_cnt_d  = mem_cnt_q + 1'b1;
      end
      GNT_RD: begin
        mem_dir    = rd_ptr_q;
        rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        mem_cnt_d  = mem_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      rd_pend_q <= rd_pend_d;
      last_wr_q <= last_wr_d;
    end
  end

  sram_fifo_oq #(.DATA_W(DATA_W)) u_oq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (rd_pend_q),
    .push_dat_i (mem_dato_s),
    .pop_i      (pop_hs),
    .vld_o      (pop_valid),
    .head_o     (pop_data),
    .cnt_o      (oq_cnt)
  );

`ifdef SRAM_FIFO_STATUS_EN
  logic [1:0]       oq_cnt_d;
  logic [CNT_W:0]   occ_sum;
  logic [CNT_W-1:0] count_q;
  logic             almost_full_q;

  // Status registers track next-state occupancy so they line up with the state they describe.
  assign oq_cnt_d = oq_cnt + {1'b0, rd_pend_q} - {1'b0, pop_hs};
  assign occ_sum  = {1'b0, mem_cnt_d} + (CNT_W+1)'(rd_pend_d) + (CNT_W+1)'(oq_cnt_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      count_q       <= occ_sum[CNT_W] ? '1 : occ_sum[CNT_W-1:0];
      almost_full_q <= (mem_cnt_d >= CNT_W'(DEPTH - 2));
    end
  end

  assign count       = count_q;
  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with DEPTH=12 over a behavioural single-port SRAM.
module tb_sram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_data = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [DW-1:0] pop_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_dir;
  logic [DW-1:0] mem_dato_e;
  logic [DW-1:0] mem_dato_s = '0;
`ifdef SRAM_FIFO_STATUS_EN
  logic [AW:0]   count;
  logic          almost_full;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int wr_model = 0;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] got_q[$];
  logic [AW-1:0] wdir_q[$];
  logic [1:0]    ew_q[$];

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_dir    (mem_dir),
    .mem_dato_e (mem_dato_e),
    .mem_dato_s (mem_dato_s)
`ifdef SRAM_FIFO_STATUS_EN
    ,
    .count      (count),
    .almost_full(almost_full)
`endif
  );

  // SRAM_S stand-in: synchronous write, registered read data one cycle later.
  logic [DW-1:0] sram [0:15];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_dir] <= mem_dato_e;
      else        mem_dato_s    <= sram[mem_dir];
    end
  end

  // Called at a falling edge: drive, sample 1 ns later, return at the next falling edge.
  task automatic cycle(input logic pv, input logic [DW-1:0] pd, input logic pr,
                       output logic acc, output logic popped, output logic [DW-1:0] pdat,
                       output logic en, output logic we, output logic [AW-1:0] dir);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    #1;
    acc    = pv && push_ready;
    popped = pop_valid && pr;
    pdat   = pop_data;
    en     = mem_en;
    we     = mem_we;
    dir    = mem_dir;
    @(negedge clk);
  endtask

  task automatic run_stream(input int n, input int base, input logic pr, input int bound,
                            output int acc_n);
    logic a, p, e, w;
    logic [DW-1:0] d;
    logic [AW-1:0] r;
    acc_n = 0;
    for (int c = 0; c < bound && acc_n < n; c++) begin
      cycle(1'b1, DW'(base + acc_n), pr, a, p, d, e, w, r);
      ew_q.push_back({e, w});
      if (a) begin
        in_q.push_back(DW'(base + acc_n));
        wdir_q.push_back(r);
        acc_n++;
      end
      if (p) got_q.push_back(d);
    end
    push_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    logic a, p, e, w;
    logic [DW-1:0] d;
    logic [AW-1:0] r;
    for (int c = 0; c < cycles; c++) begin
      cycle(1'b0, '0, 1'b1, a, p, d, e, w, r);
      if (p) got_q.push_back(d);
    end
    pop_ready = 1'b0;
  endtask

  task automatic clear_q();
    in_q.delete();
    got_q.delete();
    wdir_q.delete();
    ew_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pop_valid got %b want 0", pop_valid); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    n_cmp++; if (pop_data !== 8'h00) begin n_bad++; $display("FAIL reset_pop_data got %h want 00", pop_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL idle_mem_en got %b want 0", mem_en); end
`ifdef SRAM_FIFO_STATUS_EN
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
`endif
    push_valid = 1'b1;
    #1;
    n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL reset_mem_we got %b want 1", mem_we); end
    push_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_order();
    int acc;
    clear_q();
    run_stream(12, 220, 1'b0, 80, acc);
    n_cmp++; if (acc != 12) begin n_bad++; $display("FAIL order_accepted got %0d want 12", acc); end
    for (int i = 0; i < wdir_q.size(); i++) begin
      n_cmp++; if (wdir_q[i] !== AW'(i)) begin n_bad++; $display("FAIL order_wr_dir[%0d] got %0d want %0d", i, wdir_q[i], i); end
    end
    drain(60);
    n_cmp++; if (got_q.size() != 12) begin n_bad++; $display("FAIL order_pop_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== DW'(220 + i)) begin
        n_bad++; $display("FAIL order_data[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, DW'(220 + i));
      end
    end
    wr_model = (wr_model + 12) % DP;
  endtask

  task automatic test_full();
    int acc;
    logic a, p, e, w;
    logic [DW-1:0] d;
    logic [AW-1:0] r;
    clear_q();
    run_stream(14, 100, 1'b0, 100, acc);
    n_cmp++; if (acc != 14) begin n_bad++; $display("FAIL full_accepted got %0d want 14", acc); end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 8'hEE, 1'b0, a, p, d, e, w, r);
      n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL full_push_ready[%0d] got %b want 0", c, a); end
    end
    push_valid = 1'b0;
`ifdef SRAM_FIFO_STATUS_EN
    #1;
    n_cmp++; if (count !== 5'd14) begin n_bad++; $display("FAIL full_count got %0d want 14", count); end
    n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL full_almost_full got %b want 1", almost_full); end
    @(negedge clk);
`endif
    drain(60);
    n_cmp++; if (got_q.size() != 14) begin n_bad++; $display("FAIL full_pop_count got %0d want 14", got_q.size()); end
    for (int i = 0; i < 14; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== DW'(100 + i)) begin
        n_bad++; $display("FAIL full_data[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, DW'(100 + i));
      end
    end
    wr_model = (wr_model + 14) % DP;
  endtask

  task automatic test_latency();
    logic a, p, e, w;
    logic [DW-1:0] d;
    logic [AW-1:0] r;
    cycle(1'b1, 8'd55, 1'b1, a, p, d, e, w, r);
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL lat_accept got %b want 1", a); end
    n_cmp++; if (r !== AW'(wr_model)) begin n_bad++; $display("FAIL lat_wr_dir got %0d want %0d", r, wr_model); end
    wr_model = (wr_model + 1) % DP;
    for (int c = 1; c <= 3; c++) begin
      cycle(1'b0, '0, 1'b1, a, p, d, e, w, r);
      n_cmp++; if (p !== (c == 3)) begin n_bad++; $display("FAIL lat_pop_valid[edge+%0d] got %b want %b", c - 1, p, c == 3); end
    end
    n_cmp++; if (d !== 8'd55) begin n_bad++; $display("FAIL lat_data got %h want 37", d); end
    pop_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc;
    clear_q();
    run_stream(1000, 10, 1'b1, 40, acc);
    n_cmp++; if (acc != 20) begin n_bad++; $display("FAIL b2b_accepted got %0d want 20", acc); end
    for (int i = 0; i < ew_q.size(); i++) begin
      n_cmp++;
      if (ew_q[i] !== {1'b1, (i % 2) == 0}) begin
        n_bad++; $display("FAIL b2b_en_we[%0d] got %b want %b", i, ew_q[i], {1'b1, (i % 2) == 0});
      end
    end
    for (int i = 0; i < wdir_q.size(); i++) begin
      n_cmp++; if (wdir_q[i] !== AW'(wr_model)) begin n_bad++; $display("FAIL b2b_wr_dir[%0d] got %0d want %0d", i, wdir_q[i], wr_model); end
      wr_model = (wr_model + 1) % DP;
    end
    drain(20);
    n_cmp++; if (got_q.size() != in_q.size()) begin n_bad++; $display("FAIL b2b_pop_count got %0d want %0d", got_q.size(), in_q.size()); end
    for (int i = 0; i < in_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== in_q[i]) begin
        n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, in_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int acc;
    int wraps;
    clear_q();
    wraps = 0;
    run_stream(30, 150, 1'b1, 100, acc);
    n_cmp++; if (acc != 30) begin n_bad++; $display("FAIL wrap_accepted got %0d want 30", acc); end
    for (int i = 0; i < wdir_q.size(); i++) begin
      n_cmp++; if (wdir_q[i] !== AW'(wr_model)) begin n_bad++; $display("FAIL wrap_wr_dir[%0d] got %0d want %0d", i, wdir_q[i], wr_model); end
      wr_model = (wr_model + 1) % DP;
      if (i > 0 && wdir_q[i-1] == AW'(DP - 1) && wdir_q[i] == '0) wraps++;
    end
    n_cmp++; if (wraps < 2) begin n_bad++; $display("FAIL wrap_count got %0d want >=2", wraps); end
    drain(30);
    n_cmp++; if (got_q.size() != 30) begin n_bad++; $display("FAIL wrap_pop_count got %0d want 30", got_q.size()); end
    for (int i = 0; i < 30; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== DW'(150 + i)) begin
        n_bad++; $display("FAIL wrap_data[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, DW'(150 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    logic a, p, e, w;
    logic [DW-1:0] d;
    logic [AW-1:0] r;
    clear_q();
    run_stream(5, 60, 1'b0, 40, acc);
    n_cmp++; if (acc != 5) begin n_bad++; $display("FAIL rst_pre_accepted got %0d want 5", acc); end
    repeat (4) cycle(1'b0, '0, 1'b0, a, p, d, e, w, r);
    #1;
    n_cmp++; if (pop_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_pop_valid got %b want 1", pop_valid); end
    push_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pop_valid got %b want 0", pop_valid); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid_mem_en got %b want 0", mem_en); end
    n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_push_ready got %b want 0", push_ready); end
    @(negedge clk);
    push_valid = 1'b0;
    rst_n = 1'b1;
    wr_model = 0;
    #1;
`ifdef SRAM_FIFO_STATUS_EN
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL rst_post_count got %0d want 0", count); end
`endif
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL rst_post_pop_valid got %b want 0", pop_valid); end
    @(negedge clk);
    cycle(1'b1, 8'd77, 1'b1, a, p, d, e, w, r);
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL rst_post_accept got %b want 1", a); end
    n_cmp++; if (r !== AW'(0)) begin n_bad++; $display("FAIL rst_post_wr_dir got %0d want 0", r); end
    repeat (2) cycle(1'b0, '0, 1'b1, a, p, d, e, w, r);
    cycle(1'b0, '0, 1'b1, a, p, d, e, w, r);
    n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL rst_post_pop got %b want 1", p); end
    n_cmp++; if (d !== 8'd77) begin n_bad++; $display("FAIL rst_post_data got %h want 4d", d); end
    pop_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_order();
    test_full();
    test_latency();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
